rc5_key_expand: RTL and testbench
=================================

RC5_KEY_EXPAND -- requirements
Module: rc5_key_expand

Interface
REQ-001 Parameter P_CONST, default 32'hB7E15163, RC5-32 magic constant P.
REQ-002 Parameter Q_CONST, default 32'h9E3779B9, RC5-32 magic constant Q.
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 clr  input  1  Reset, synchronous, active-high.
REQ-005 key_in  input  128  User key K[0..15]; byte k = key_in[8k+7:8k]; word L[w] = key_in[32w+31:32w].
REQ-006 key_vld  input  1  Key-load request; sampled only while ready=1.
REQ-007 ready  output  1  High in IDLE or DONE; block accepts key_vld.
REQ-008 done  output  1  High only in DONE; skey_out holds the complete schedule.
REQ-009 skey_out  output  832  Round-key table; S[i] = skey_out[32i+31:32i], i=0..25, direct feed to the encrypt/decrypt key input.

Function
REQ-010 The FSM SHALL have the states IDLE, INIT, MIX and DONE, held in a registered state variable.
REQ-011 IDLE/DONE with key_vld=1 at an edge: latch L[0..3] from key_in; clear init index; state->INIT; done->0.
REQ-012 INIT SHALL write one entry per cycle: S[0]=P_CONST, then S[k]=S[k-1]+Q_CONST mod 2^32, k=1..25; after the 26th write, state->MIX.
REQ-013 MIX entry SHALL zero A, B, i, j and the iteration counter n.
REQ-014 Each MIX cycle SHALL perform one iteration: A'=rotl(S[i]+A+B,3); B'=rotl(L[j]+A'+B,(A'+B)[4:0]); S[i]=A'; L[j]=B'; A=A'; B=B'.
REQ-015 Additions SHALL be 32-bit modulo 2^32; rotation amount uses only bits [4:0]; rotate by 0 returns the operand unchanged (no shift-by-32 term).
REQ-016 i SHALL wrap 25->0 and j SHALL wrap 3->0, both incrementing every MIX cycle.
REQ-017 After iteration n=77 (the 78th iteration) state->DONE and done->1 on that same edge.
REQ-018 Latency: key accepted at edge E0; INIT on E1..E26; MIX on E27..E104; done=1 after E104 (105 edges total).
REQ-019 key_vld in INIT or MIX SHALL be ignored; key_in changes during that time SHALL NOT affect the result.
REQ-020 DONE SHALL hold skey_out and done stable indefinitely until clr or a new accepted key_vld.
REQ-021 ready SHALL be combinational from state: 1 in IDLE/DONE, 0 in INIT/MIX.
REQ-022 skey_out SHALL be driven continuously from the S registers; contents are valid only while done=1.

Reset
REQ-023 clr=1 at an edge SHALL force state->IDLE; done=0; S[0..25], L[0..3], A, B, i, j, n all 0; hence skey_out=0 and ready=1.
REQ-024 clr SHALL take priority over key_vld and SHALL abort INIT/MIX mid-operation with no partial result marked valid.
REQ-025 The first key_vld with clr=0 after reset SHALL be accepted normally.

Verification
REQ-026 Zero key, key_vld pulse -> done after exactly 105 edges; ready=0 for edges E1..E104.
REQ-027 Snoop at end of INIT (zero key) -> S[0]=32'hB7E15163, S[1]=32'h5618CB1C, S[25]=P_CONST+25*Q_CONST mod 2^32.
REQ-028 Zero key, skey_out fed to encrypt with plaintext 64'h0 -> ciphertext {A,B} = 64'h21A5DBEE154B8F6D (Rivest RC5-32/12/16 vector 1).
REQ-029 clr asserted at edge E50 (mid-MIX) -> next cycle done=0, skey_out=0, ready=1; a reload then gives the REQ-028 result.
REQ-030 key_vld held high with key_in toggled during INIT/MIX -> result equals the key latched at E0; from DONE, new key_vld -> done drops next cycle and a new schedule completes 105 edges later.
REQ-031 Directed rotate-by-0 case (A'+B with [4:0]=0) -> B' equals L[j]+A'+B unrotated; compare against a bit-accurate reference model.

Source files
------------

// File: rtl/rc5_key_expand.sv
// rc5_key_expand
// RC5-32/12/16 key schedule generator. After a key is accepted it fills the
// 26-word round-key table S with the magic-constant progression, then runs
// 78 mixing iterations that fold the 128-bit user key into S. The table is
// presented on skey_out and is valid while done=1.
//
// Ports
//   clk       rising-edge clock
//   clr       synchronous active-high reset
//   key_in    128-bit user key, word L[w] = key_in[32w+31:32w]
//   key_vld   key-load request, honoured only while ready=1
//   ready     block idle or finished, can accept a new key
//   done      schedule complete, skey_out valid
//   skey_out  S[0..25], S[i] = skey_out[32i+31:32i]
//
// state | meaning
// IDLE  | nothing loaded since reset, waiting for key_vld
// INIT  | writing S[k] = P + k*Q, one entry per cycle
// MIX   | one key-mixing iteration per cycle, 78 in total
// DONE  | schedule valid, waiting for a new key or clr
module rc5_key_expand #(
  parameter logic [31:0] P_CONST = 32'hB7E15163,
  parameter logic [31:0] Q_CONST = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [127:0] key_in,
  input  logic         key_vld,
  output logic         ready,
  output logic         done,
  output logic [831:0] skey_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_MIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] s_q [26];
  logic [31:0] s_d [26];
  logic [31:0] l_q [4];
  logic [31:0] l_d [4];
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  i_q, i_d;
  logic [1:0]  j_q, j_d;
  logic [6:0]  n_q, n_d;

  logic [31:0] a_sum, a_new, ab_sum, b_sum, b_new;

  // Rotating the doubled word avoids any shift-by-32 term: r=0 returns x.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] r);
    logic [63:0] t;
    t = {x, x} << r;
    return t[63:32];
  endfunction

  always_comb begin
    a_sum  = s_q[i_q] + a_q + b_q;
    a_new  = rotl(a_sum, 5'd3);
    ab_sum = a_new + b_q;
    b_sum  = l_q[j_q] + ab_sum;
    b_new  = rotl(b_sum, ab_sum[4:0]);

    state_d = state_q;
    s_d     = s_q;
    l_d     = l_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    n_d     = n_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_vld) begin
          for (int w = 0; w < 4; w++) l_d[w] = key_in[32*w +: 32];
          i_d     = 5'd0;
          // During INIT, A is free and serves as the running P + k*Q value.
          a_d     = P_CONST;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        s_d[i_q] = a_q;
        a_d      = a_q + Q_CONST;
        if (i_q == 5'd25) begin
          a_d     = '0;
          b_d     = '0;
          i_d     = 5'd0;
          j_d     = 2'd0;
          n_d     = 7'd0;
          state_d = ST_MIX;
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      ST_MIX: begin
        s_d[i_q] = a_new;
        l_d[j_q] = b_new;
        a_d      = a_new;
        b_d      = b_new;
        i_d      = (i_q == 5'd25) ? 5'd0 : i_q + 5'd1;
        j_d      = j_q + 2'd1;
        n_d      = n_q + 7'd1;
        if (n_q == 7'd77) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < 26; k++) s_q[k] <= '0;
      for (int w = 0; w < 4; w++) l_q[w] <= '0;
      a_q <= '0;
      b_q <= '0;
      i_q <= '0;
      j_q <= '0;
      n_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      l_q     <= l_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      n_q     <= n_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);

  always_comb begin
    skey_out = '0;
    for (int k = 0; k < 26; k++) skey_out[32*k +: 32] = s_q[k];
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand: a cycle-level timeline model of
// ready/done plus a plain-arithmetic RC5 key schedule, compared every cycle.
module tb_rc5_key_expand;

  localparam logic [31:0] P = 32'hB7E15163;
  localparam logic [31:0] Q = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         clr;
  logic [127:0] key_in;
  logic         key_vld;
  logic         ready;
  logic         done;
  logic [831:0] skey_out;

  int checks = 0;
  int errors = 0;

  rc5_key_expand dut (
    .clk      (clk),
    .clr      (clr),
    .key_in   (key_in),
    .key_vld  (key_vld),
    .ready    (ready),
    .done     (done),
    .skey_out (skey_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int r);
    int rr;
    rr = r & 31;
    if (rr == 0) return x;
    return (x << rr) | (x >> (32 - rr));
  endfunction

  function automatic logic [831:0] m_expand(input logic [127:0] k, output int rot0);
    logic [31:0] s [26];
    logic [31:0] l [4];
    logic [31:0] a, b, sh;
    logic [831:0] r;
    int i, j;
    for (int w = 0; w < 4; w++) l[w] = k[32*w +: 32];
    for (int t = 0; t < 26; t++) s[t] = P + Q * t;
    a = 0; b = 0; i = 0; j = 0; rot0 = 0;
    for (int n = 0; n < 78; n++) begin
      a    = m_rotl(s[i] + a + b, 3);
      s[i] = a;
      sh   = a + b;
      if (sh[4:0] == 5'd0) rot0++;
      b    = m_rotl(l[j] + a + b, int'(sh[4:0]));
      l[j] = b;
      i    = (i + 1) % 26;
      j    = (j + 1) % 4;
    end
    for (int t = 0; t < 26; t++) r[32*t +: 32] = s[t];
    return r;
  endfunction

  function automatic logic [63:0] m_encrypt(input logic [831:0] sk, input logic [31:0] pa,
                                            input logic [31:0] pb);
    logic [31:0] a, b;
    a = pa + sk[31:0];
    b = pb + sk[63:32];
    for (int r = 1; r <= 12; r++) begin
      a = m_rotl(a ^ b, int'(b[4:0])) + sk[64*r +: 32];
      b = m_rotl(b ^ a, int'(a[4:0])) + sk[64*r+32 +: 32];
    end
    return {a, b};
  endfunction

  // The published vector is a byte stream; RC5 words are little-endian.
  function automatic logic [63:0] to_bytes(input logic [63:0] ab);
    logic [31:0] a, b;
    a = ab[63:32];
    b = ab[31:0];
    return {a[7:0], a[15:8], a[23:16], a[31:24], b[7:0], b[15:8], b[23:16], b[31:24]};
  endfunction

  // Timeline: busy counts edges left until done; 104 right after acceptance.
  int           busy   = 0;
  bit           m_done = 1'b0;
  bit           m_zero = 1'b1;
  logic [127:0] m_key  = '0;
  logic [831:0] m_sk   = '0;
  logic [831:0] init_tab;
  bit           en_cmp = 1'b0;
  bit           pinned = 1'b0;
  int           dummy_rot0;

  always @(posedge clk) begin
    if (clr) begin
      busy = 0; m_done = 0; m_zero = 1;
    end else if (busy == 0 && key_vld) begin
      busy = 104; m_done = 0; m_zero = 0; m_key = key_in;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        m_done = 1;
        m_sk   = m_expand(m_key, dummy_rot0);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_sk(input string nm, input logic [831:0] got, input logic [831:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int k = 0; k < 26; k++)
      if (bad < 0 && got[32*k +: 32] !== exp[32*k +: 32]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s S[%0d] got %h exp %h at %0t", nm, bad, got[32*bad +: 32],
               exp[32*bad +: 32], $time);
    end
  endtask

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("ready", {63'd0, ready}, {63'd0, busy == 0});
      chk("done", {63'd0, done}, {63'd0, m_done});
      if (m_done) chk_sk("skey_done", skey_out, m_sk);
      else if (m_zero) chk_sk("skey_clr", skey_out, '0);
      else if (busy == 78) begin
        chk_sk("skey_init", skey_out, init_tab);
        if (!pinned) begin
          pinned = 1'b1;
          chk("init_s0", {32'd0, skey_out[31:0]}, {32'd0, 32'hB7E15163});
          chk("init_s1", {32'd0, skey_out[63:32]}, {32'd0, 32'h5618CB1C});
          chk("init_s25", {32'd0, skey_out[831:800]}, {32'd0, 32'h2B4C3474});
        end
      end
    end
  end

  // Called at a negedge; returns the number of edges from acceptance (E0)
  // through the edge after which done is first seen.
  task automatic run_key(input logic [127:0] k, input bit hold, input bit toggle,
                         output int edges);
    key_in  = k;
    key_vld = 1'b1;
    edges   = 0;
    @(posedge clk);
    edges++;
    @(negedge clk);
    if (!hold) key_vld = 1'b0;
    while (!done && edges < 300) begin
      if (toggle) key_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    key_vld = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int edges, r0;
    logic [127:0] k;
    for (int t = 0; t < 26; t++) init_tab[32*t +: 32] = P + Q * t;

    clr = 1'b1; key_vld = 1'b0; key_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    en_cmp = 1'b1;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk_sk("rst_skey", skey_out, '0);
    // key_vld together with clr is ignored
    key_vld = 1'b1;
    @(negedge clk);
    chk("clr_prio_ready", {63'd0, ready}, 64'd1);
    key_vld = 1'b0;
    clr = 1'b0;
    @(negedge clk);

    // zero key: latency, test vector, and model pinned to the vector
    run_key('0, 1'b0, 1'b0, edges);
    chk("lat_zero", edges, 105);
    chk("vec1_dut", to_bytes(m_encrypt(skey_out, 32'd0, 32'd0)), 64'h21A5DBEE154B8F6D);
    chk("vec1_model", to_bytes(m_encrypt(m_expand('0, r0), 32'd0, 32'd0)),
        64'h21A5DBEE154B8F6D);
    repeat (3) @(negedge clk);

    // random keys, key_vld sometimes held, key_in toggled while busy
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_key(k, 1'($urandom_range(0, 1)), 1'b1, edges);
      chk("lat_rand", edges, 105);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // key with at least one zero rotation amount in the mixing
    k = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < 50; t++) begin
      void'(m_expand(k, r0));
      if (r0 == 0) k = {$urandom, $urandom, $urandom, $urandom};
    end
    run_key(k, 1'b0, 1'b0, edges);
    chk("lat_rot0", edges, 105);

    // abort at E50 mid-mix, then reload the zero key
    @(negedge clk);
    key_in = '0; key_vld = 1'b1;
    @(negedge clk);
    key_vld = 1'b0;
    repeat (49) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk_sk("abort_skey", skey_out, '0);
    clr = 1'b0;
    @(negedge clk);
    run_key('0, 1'b0, 1'b1, edges);
    chk("lat_reload", edges, 105);
    chk("vec1_reload", to_bytes(m_encrypt(skey_out, 32'd0, 32'd0)), 64'h21A5DBEE154B8F6D);

    // DONE holds steady
    repeat (5) @(negedge clk);
    chk("hold_done", {63'd0, done}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
